simon_seq_player: RTL and testbench

- Consumer end of the 2-bit random colour stream from the RNG core.
- Each game it re-seeds the RNG, then each round appends one colour to a sequence memory.
- It replays the whole sequence on the LEDs, then checks the player's button presses against it.
- Sits between the RNG and the board I/O (LED driver, debounced button encoder).

---
 rtl/simon_seq_player_pkg.sv | 32 +++
 rtl/simon_seq_player_seq_mem.sv | 56 +++++
 rtl/simon_seq_player.sv | 176 +++++++++++++++++
 tb/tb_simon_seq_player.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_seq_player_pkg.sv
// Shared types and helpers for the Simon sequence player.
// Colour codes, FSM state encoding and the LED decode used by every file.
package simon_pkg;

   typedef logic [1:0] colour_t;

   typedef enum logic [3:0] {
      IDLE,
      SEED,
      PRIME,
      APPEND,
      SHOW_ON,
      SHOW_OFF,
      WAIT_IN,
      WIN,
      LOSE
   } state_t;

   localparam logic [3:0] LED_OFF = 4'b0000;
   localparam logic [3:0] LED_ALL = 4'b1111;

   function automatic logic [3:0] onehot_led(input colour_t c);
      case (c)
         2'd0:    onehot_led = 4'b0001;
         2'd1:    onehot_led = 4'b0010;
         2'd2:    onehot_led = 4'b0100;
         2'd3:    onehot_led = 4'b1000;
         default: onehot_led = 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/simon_seq_player_seq_mem.sv
// Colour sequence register file: one write port at len, a compare read at idx,
// and a playback read that forwards the colour being appended in the same cycle.
module seq_mem
   import simon_pkg::*;
#(
   parameter int MAX_LEN = 32,
   parameter int LW      = $clog2(MAX_LEN + 1)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [LW-1:0] wr_ptr_i,
   input  colour_t       wdata_i,
   input  logic [LW-1:0] cmp_ptr_i,
   output colour_t       cmp_data_o,
   input  logic [LW-1:0] show_ptr_i,
   output colour_t       show_data_o
);

   localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [LW-1:0] DEPTH = LW'(MAX_LEN);

   colour_t    mem_q [MAX_LEN];
   logic [AW-1:0] wr_a_s;
   logic [AW-1:0] cmp_a_s;
   logic [AW-1:0] show_a_s;

   assign wr_a_s   = wr_ptr_i[AW-1:0];
   assign cmp_a_s  = cmp_ptr_i[AW-1:0];
   assign show_a_s = show_ptr_i[AW-1:0];

   // Synchronous write; contents are not reset because a game always rewrites before reading
   always_ff @(posedge clk) begin
      if (we_i && (wr_ptr_i < DEPTH)) begin
         mem_q[wr_a_s] <= wdata_i;
      end
   end

   // Asynchronous reads; out-of-range pointers read as colour 0
   always_comb begin
      cmp_data_o  = 2'd0;
      show_data_o = 2'd0;
      if (cmp_ptr_i < DEPTH) begin
         cmp_data_o = mem_q[cmp_a_s];
      end else begin
         cmp_data_o = 2'd0;
      end
      if (we_i && (wr_ptr_i == show_ptr_i)) begin
         show_data_o = wdata_i;
      end else if (show_ptr_i < DEPTH) begin
         show_data_o = mem_q[show_a_s];
      end else begin
         show_data_o = 2'd0;
      end
   end

endmodule

// File: rtl/simon_seq_player.sv
// Simon game sequencer: seeds the RNG, grows the colour sequence one round at a
// time, plays it back on the LEDs and checks the player's presses.
module simon_seq_player
   import simon_pkg::*;
#(
   parameter int MAX_LEN    = 32,
   parameter int ON_CYCLES  = 50000000,
   parameter int OFF_CYCLES = 25000000
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start_i,
   input  logic [1:0]                     rand_i,
   output logic                           loadseed_o,
   input  logic                           btn_valid_i,
   input  logic [1:0]                     btn_i,
   output logic [3:0]                     led_o,
   output logic                           busy_o,
   output logic [$clog2(MAX_LEN+1)-1:0]   round_o,
   output logic                           win_o,
   output logic                           lose_o
);

   localparam int LW   = $clog2(MAX_LEN + 1);
   localparam int TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);

   localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
   localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);
   localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);

   state_t        state_q;
   logic [LW-1:0] len_q;
   logic [LW-1:0] idx_q;
   logic [TW-1:0] tmr_q;
   logic [3:0]    led_q;
   logic          loadseed_q;
   logic          busy_q;
   logic          win_q;
   logic          lose_q;

   logic          we_s;
   logic          last_s;
   logic [LW-1:0] show_ptr_s;
   colour_t       cmp_colour_s;
   colour_t       show_colour_s;

   // The playback read looks one step ahead so led_o is registered in step with the state
   always_comb begin
      we_s       = (state_q == APPEND);
      last_s     = (idx_q == (len_q - LW'(1)));
      show_ptr_s = LW'(0);
      if (state_q == APPEND) begin
         show_ptr_s = LW'(0);
      end else begin
         show_ptr_s = idx_q + LW'(1);
      end
   end

   seq_mem #(
      .MAX_LEN (MAX_LEN),
      .LW      (LW)
   ) u_seq_mem (
      .clk         (clk),
      .we_i        (we_s),
      .wr_ptr_i    (len_q),
      .wdata_i     (rand_i),
      .cmp_ptr_i   (idx_q),
      .cmp_data_o  (cmp_colour_s),
      .show_ptr_i  (show_ptr_s),
      .show_data_o (show_colour_s)
   );

   // Game FSM with its timer, pointers and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         len_q      <= '0;
         idx_q      <= '0;
         tmr_q      <= '0;
         led_q      <= LED_OFF;
         loadseed_q <= 1'b0;
         busy_q     <= 1'b0;
         win_q      <= 1'b0;
         lose_q     <= 1'b0;
      end else begin
         loadseed_q <= 1'b0;
         case (state_q)
            IDLE, WIN, LOSE: begin
               if (start_i) begin
                  state_q    <= SEED;
                  loadseed_q <= 1'b1;
                  busy_q     <= 1'b1;
                  win_q      <= 1'b0;
                  lose_q     <= 1'b0;
                  led_q      <= LED_OFF;
                  len_q      <= '0;
                  idx_q      <= '0;
               end else begin
                  state_q <= state_q;
               end
            end
            SEED:  state_q <= PRIME;
            PRIME: state_q <= APPEND;
            APPEND: begin
               len_q   <= len_q + LW'(1);
               idx_q   <= '0;
               tmr_q   <= '0;
               led_q   <= onehot_led(show_colour_s);
               state_q <= SHOW_ON;
            end
            SHOW_ON: begin
               if (tmr_q == ON_LAST) begin
                  tmr_q   <= '0;
                  led_q   <= LED_OFF;
                  state_q <= SHOW_OFF;
               end else begin
                  tmr_q <= tmr_q + TW'(1);
               end
            end
            SHOW_OFF: begin
               if (tmr_q == OFF_LAST) begin
                  tmr_q <= '0;
                  if (last_s) begin
                     idx_q   <= '0;
                     state_q <= WAIT_IN;
                  end else begin
                     idx_q   <= idx_q + LW'(1);
                     led_q   <= onehot_led(show_colour_s);
                     state_q <= SHOW_ON;
                  end
               end else begin
                  tmr_q <= tmr_q + TW'(1);
               end
            end
            WAIT_IN: begin
               if (btn_valid_i) begin
                  if (btn_i != cmp_colour_s) begin
                     state_q <= LOSE;
                     lose_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end else if (last_s) begin
                     if (len_q == LEN_MAX) begin
                        state_q <= WIN;
                        win_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        led_q   <= LED_ALL;
                     end else begin
                        state_q <= APPEND;
                     end
                  end else begin
                     idx_q <= idx_q + LW'(1);
                  end
               end else begin
                  state_q <= WAIT_IN;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               led_q   <= LED_OFF;
               win_q   <= 1'b0;
               lose_q  <= 1'b0;
            end
         endcase
      end
   end

   assign loadseed_o = loadseed_q;
   assign led_o      = led_q;
   assign busy_o     = busy_q;
   assign round_o    = len_q;
   assign win_o      = win_q;
   assign lose_o     = lose_q;

endmodule

// File: tb/tb_simon_seq_player.sv
// Self-checking bench for simon_seq_player: table of single-round games,
// hand-written corner sequences, and random games against a queue-based model.
module tb_simon_seq_player;
   import simon_pkg::*;

   localparam int MAX_LEN = 3;
   localparam int ON      = 3;
   localparam int OFF     = 2;
   localparam int LW      = $clog2(MAX_LEN + 1);

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start_i = 1'b0;
   logic          btn_valid_i = 1'b0;
   logic [1:0]    rand_i = 2'd0;
   logic [1:0]    btn_i = 2'd0;
   logic          loadseed_o;
   logic [3:0]    led_o;
   logic          busy_o;
   logic [LW-1:0] round_o;
   logic          win_o;
   logic          lose_o;

   int total = 0;
   int bad   = 0;
   logic [1:0] model_seq [$];

   typedef struct {
      logic [1:0] col;
      logic [1:0] btn;
      logic       exp_lose;
   } vec_t;
   vec_t vecs [6];

   always #5 clk = ~clk;

   simon_seq_player #(
      .MAX_LEN    (MAX_LEN),
      .ON_CYCLES  (ON),
      .OFF_CYCLES (OFF)
   ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .start_i     (start_i),
      .rand_i      (rand_i),
      .loadseed_o  (loadseed_o),
      .btn_valid_i (btn_valid_i),
      .btn_i       (btn_i),
      .led_o       (led_o),
      .busy_o      (busy_o),
      .round_o     (round_o),
      .win_o       (win_o),
      .lose_o      (lose_o)
   );

   function automatic logic [3:0] led_of(input logic [1:0] c);
      logic [3:0] one;
      one = 4'b0001;
      return one << c;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_idle_outs(input string nm);
      chk({nm, "_led"}, led_o, 4'b0000);
      chk({nm, "_busy"}, busy_o, 1'b0);
      chk({nm, "_round"}, round_o, 0);
      chk({nm, "_win"}, win_o, 1'b0);
      chk({nm, "_lose"}, lose_o, 1'b0);
      chk({nm, "_seed"}, loadseed_o, 1'b0);
   endtask

   // Asynchronous reset mid-cycle; outputs must clear before the next edge
   task automatic do_reset();
      start_i = 1'b0;
      btn_valid_i = 1'b0;
      #2 reset = 1'b0;
      #1 chk_idle_outs("rst_async");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk_idle_outs("rst_idle");
   endtask

   // Called at a negedge; returns at the first SHOW_ON negedge with the model updated
   task automatic start_game(input logic [1:0] c);
      start_i = 1'b1;
      rand_i  = c;
      @(negedge clk);
      start_i = 1'b0;
      chk("seed_pulse", loadseed_o, 1'b1);
      chk("seed_busy", busy_o, 1'b1);
      chk("seed_round", round_o, 0);
      chk("seed_win", win_o, 1'b0);
      chk("seed_lose", lose_o, 1'b0);
      @(negedge clk);
      chk("prime_seed", loadseed_o, 1'b0);
      chk("prime_busy", busy_o, 1'b1);
      @(negedge clk);
      chk("append_round", round_o, 0);
      chk("append_led", led_o, 4'b0000);
      @(negedge clk);
      model_seq.delete();
      model_seq.push_back(c);
   endtask

   task automatic playback(input bit inject);
      for (int i = 0; i < model_seq.size(); i++) begin
         for (int k = 0; k < ON; k++) begin
            chk("show_on_led", led_o, led_of(model_seq[i]));
            chk("show_busy", busy_o, 1'b1);
            chk("show_round", round_o, model_seq.size());
            if (inject && k == 0) begin
               btn_valid_i = 1'b1;
               btn_i = ~model_seq[i];
            end
            @(negedge clk);
            btn_valid_i = 1'b0;
         end
         for (int k = 0; k < OFF; k++) begin
            chk("show_off_led", led_o, 4'b0000);
            @(negedge clk);
         end
      end
      chk("wait_led", led_o, 4'b0000);
      chk("wait_busy", busy_o, 1'b1);
   endtask

   task automatic press(input logic [1:0] b);
      btn_valid_i = 1'b1;
      btn_i = b;
      @(negedge clk);
      btn_valid_i = 1'b0;
   endtask

   // All correct presses; rand_i is set to nxt before the round completes
   task automatic press_all(input logic [1:0] nxt);
      for (int i = 0; i < model_seq.size(); i++) begin
         if (i == model_seq.size() - 1) rand_i = nxt;
         press(model_seq[i]);
         if (i != model_seq.size() - 1) begin
            chk("mid_press_busy", busy_o, 1'b1);
            chk("mid_press_lose", lose_o, 1'b0);
         end
      end
   endtask

   task automatic next_round(input logic [1:0] nxt);
      chk("next_append_round", round_o, model_seq.size());
      chk("next_append_busy", busy_o, 1'b1);
      @(negedge clk);
      model_seq.push_back(nxt);
   endtask

   task automatic random_game();
      logic [1:0] c, b, nc;
      bit lost, wrong, last;
      int gap;
      c = 2'($urandom_range(0, 3));
      start_game(c);
      for (int r = 0; r < MAX_LEN; r++) begin
         playback(1'b0);
         lost = 1'b0;
         nc = 2'd0;
         for (int i = 0; i < model_seq.size(); i++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
               chk("rnd_gap_led", led_o, 4'b0000);
               chk("rnd_gap_busy", busy_o, 1'b1);
               @(negedge clk);
            end
            wrong = ($urandom_range(0, 9) == 0);
            b = wrong ? (model_seq[i] ^ 2'($urandom_range(1, 3))) : model_seq[i];
            last = (i == model_seq.size() - 1);
            if (last && !wrong && model_seq.size() < MAX_LEN) begin
               nc = 2'($urandom_range(0, 3));
               rand_i = nc;
            end
            press(b);
            if (wrong) begin
               chk("rnd_lose", lose_o, 1'b1);
               chk("rnd_lose_busy", busy_o, 1'b0);
               chk("rnd_lose_led", led_o, 4'b0000);
               chk("rnd_lose_round", round_o, model_seq.size());
               lost = 1'b1;
               break;
            end else if (!last) begin
               chk("rnd_mid_lose", lose_o, 1'b0);
               chk("rnd_mid_busy", busy_o, 1'b1);
            end
         end
         if (lost) break;
         if (model_seq.size() == MAX_LEN) begin
            chk("rnd_win", win_o, 1'b1);
            chk("rnd_win_led", led_o, 4'b1111);
            chk("rnd_win_busy", busy_o, 1'b0);
            chk("rnd_win_round", round_o, MAX_LEN);
            break;
         end
         next_round(nc);
      end
   endtask

   initial begin
      vecs[0] = '{col: 2'd0, btn: 2'd0, exp_lose: 1'b0};
      vecs[1] = '{col: 2'd1, btn: 2'd1, exp_lose: 1'b0};
      vecs[2] = '{col: 2'd3, btn: 2'd3, exp_lose: 1'b0};
      vecs[3] = '{col: 2'd2, btn: 2'd0, exp_lose: 1'b1};
      vecs[4] = '{col: 2'd1, btn: 2'd2, exp_lose: 1'b1};
      vecs[5] = '{col: 2'd3, btn: 2'd1, exp_lose: 1'b1};

      #3 chk_idle_outs("por");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk_idle_outs("por_idle");

      // Single-round table: one colour, one press
      foreach (vecs[v]) begin
         do_reset();
         start_game(vecs[v].col);
         playback(1'b0);
         rand_i = 2'($urandom_range(0, 3));
         press(vecs[v].btn);
         chk("tbl_lose", lose_o, vecs[v].exp_lose);
         chk("tbl_busy", busy_o, !vecs[v].exp_lose);
         chk("tbl_round", round_o, 1);
         chk("tbl_led", led_o, 4'b0000);
      end

      // Reset in the middle of SHOW_ON
      do_reset();
      start_game(2'd2);
      chk("abort_led_before", led_o, 4'b0100);
      @(negedge clk);
      do_reset();

      // Sequence {2,1}: ignored press during playback, ignored start in WAIT_IN, then lose
      start_game(2'd2);
      playback(1'b0);
      press_all(2'd1);
      next_round(2'd1);
      playback(1'b1);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      chk("ign_start_seed", loadseed_o, 1'b0);
      chk("ign_start_busy", busy_o, 1'b1);
      chk("ign_start_round", round_o, 2);
      press(2'd2);
      chk("seq21_mid_lose", lose_o, 1'b0);
      press(2'd3);
      chk("seq21_lose", lose_o, 1'b1);
      chk("seq21_round", round_o, 2);
      chk("seq21_busy", busy_o, 1'b0);
      @(negedge clk);
      chk("seq21_lose_hold", lose_o, 1'b1);

      // Full win {0,3,1} then restart
      start_game(2'd0);
      playback(1'b0);
      press_all(2'd3);
      next_round(2'd3);
      playback(1'b0);
      press_all(2'd1);
      next_round(2'd1);
      playback(1'b0);
      press_all(2'd0);
      chk("win_flag", win_o, 1'b1);
      chk("win_led", led_o, 4'b1111);
      chk("win_busy", busy_o, 1'b0);
      chk("win_round", round_o, 3);
      @(negedge clk);
      chk("win_hold", win_o, 1'b1);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      chk("restart_win", win_o, 1'b0);
      chk("restart_seed", loadseed_o, 1'b1);
      chk("restart_round", round_o, 0);
      chk("restart_led", led_o, 4'b0000);
      do_reset();

      for (int g = 0; g < 25; g++) begin
         random_game();
         @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
